// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the main decoder:
// FSM encoding, opcode constants and datapath widths.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_W    = 6;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // beq word offset, sign-extended and scaled to bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: request/address out, data/ready back.
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Combinational next-PC select: jump, taken beq, or fall-through.
module next_pc_sel
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0]        pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic               jump,
    input  logic               alu_zero,
    output logic [31:0]        next_pc
);

    logic unused_opcode;
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: PC, instruction register and fetch/execute sequencing
// for the non-pipelined MIPS core.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  imem,
    output logic [INSTR_W-1:0]  instr,
    output logic [OP_W-1:0]     opcode,
    output logic                instr_valid,
    input  logic                exec_done,
    input  logic                branch,
    input  logic                jump,
    input  logic                alu_zero,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                fetch_fault
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);
    localparam logic [31:0]   PC_INIT  = {RESET_PC[31:2], 2'b00};

    state_t               state, state_n;
    logic [31:0]          pc_n, next_pc;
    logic [INSTR_W-1:0]   instr_n;
    logic                 valid_n, req_q, req_n, fault_n;
    logic [CW-1:0]        cnt, cnt_n, cnt_inc;

    assign pc_plus4       = pc + 32'd4;
    assign opcode         = instr[31:26];
    assign imem.imem_addr = pc;
    assign imem.imem_req  = req_q;
    assign cnt_inc        = cnt + CW'(1);

    next_pc_sel u_next_pc_sel (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .branch   (branch),
        .jump     (jump),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= PC_INIT;
            instr       <= '0;
            instr_valid <= 1'b0;
            req_q       <= 1'b0;
            fetch_fault <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
            req_q       <= req_n;
            fetch_fault <= fault_n;
            cnt         <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        valid_n = instr_valid;
        req_n   = req_q;
        fault_n = fetch_fault;
        cnt_n   = cnt;
        unique case (state)
            FETCH: begin
                req_n   = 1'b1;
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (imem.imem_ready) begin
                    instr_n = imem.imem_rdata;
                    valid_n = 1'b1;
                    req_n   = 1'b0;
                    state_n = EXEC;
                end else if (cnt_inc == WAIT_LIM) begin
                    fault_n = 1'b1;
                    req_n   = 1'b0;
                    state_n = HALT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            EXEC: begin
                // ready is ignored here; only exec_done advances
                if (exec_done) begin
                    valid_n = 1'b0;
                    pc_n    = {next_pc[31:2], 2'b00};
                    state_n = FETCH;
                end
            end
            HALT: begin
                fault_n = 1'b1;
            end
            default: begin
                state_n = HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: next_pc_sel vector table plus fetch-unit sequences.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] pc, pc_plus4;
    logic        fetch_fault;

    logic [31:0] s_pc4, s_instr, s_next;
    logic        s_b, s_j, s_z;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit_if imem_if();

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_if),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .branch      (branch),
        .jump        (jump),
        .alu_zero    (alu_zero),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_fault (fetch_fault)
    );

    next_pc_sel u_sel (
        .pc_plus4 (s_pc4),
        .instr    (s_instr),
        .branch   (s_b),
        .jump     (s_j),
        .alu_zero (s_z),
        .next_pc  (s_next)
    );

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] ins;
        logic        b;
        logic        j;
        logic        z;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_if.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait", {31'd0, imem_if.imem_req}, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] word, input int lat);
        wait_req();
        repeat (lat) @(negedge clk);
        chk("no_fault", {31'd0, fetch_fault}, 32'd0);
        imem_if.imem_ready = 1'b1;
        imem_if.imem_rdata = word;
        @(negedge clk);
        imem_if.imem_ready = 1'b0;
        chk("valid", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, word);
    endtask

    task automatic do_exec(input logic b, input logic j, input logic z,
                           input logic [31:0] exp);
        exec_done = 1'b1;
        branch = b;
        jump = j;
        alu_zero = z;
        @(negedge clk);
        exec_done = 1'b0;
        branch = 1'b0;
        jump = 1'b0;
        alu_zero = 1'b0;
        chk("next_pc", pc, exp);
        chk("valid_clr", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        imem_if.imem_ready = 1'b0;
        imem_if.imem_rdata = 32'h0;

        vecs[0] = '{32'h0000_0014, 32'h1000_FFFE, 1, 0, 1, 32'h0000_000C};
        vecs[1] = '{32'h0000_0014, 32'h1000_FFFE, 1, 0, 0, 32'h0000_0014};
        vecs[2] = '{32'h4000_0004, 32'h0800_0100, 1, 1, 1, 32'h4000_0400};
        vecs[3] = '{32'h0000_0000, 32'h0000_0020, 0, 0, 0, 32'h0000_0000};
        vecs[4] = '{32'h0000_0004, 32'h1000_FFFE, 1, 0, 1, 32'hFFFF_FFFC};
        vecs[5] = '{32'hFFFF_FFF0, 32'h1000_0008, 1, 0, 1, 32'h0000_0010};
        vecs[6] = '{32'hA000_0010, 32'h0BFF_FFFF, 0, 1, 0, 32'hAFFF_FFFC};
        vecs[7] = '{32'h0000_0100, 32'h1000_0004, 0, 0, 1, 32'h0000_0100};
        vecs[8] = '{32'h0000_0100, 32'h1000_0004, 1, 0, 1, 32'h0000_0110};

        for (int i = 0; i < 9; i++) begin
            s_pc4 = vecs[i].pc4;
            s_instr = vecs[i].ins;
            s_b = vecs[i].b;
            s_j = vecs[i].j;
            s_z = vecs[i].z;
            #1;
            chk($sformatf("sel_vec%0d", i), s_next, vecs[i].exp);
        end

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

        // first fetch: valid two edges after release
        reset = 1'b0;
        @(negedge clk);
        chk("f1_req", {31'd0, imem_if.imem_req}, 32'd1);
        chk("f1_valid_early", {31'd0, instr_valid}, 32'd0);
        imem_if.imem_ready = 1'b1;
        imem_if.imem_rdata = 32'h0000_0020;
        @(negedge clk);
        imem_if.imem_ready = 1'b0;
        chk("f1_valid", {31'd0, instr_valid}, 32'd1);
        chk("f1_opcode", {26'd0, opcode}, {26'd0, OP_RTYPE});
        chk("f1_pc", pc, 32'h0);
        chk("f1_req_drop", {31'd0, imem_if.imem_req}, 32'd0);
        do_exec(0, 0, 0, 32'h4);
        chk("f1_addr", imem_if.imem_addr, 32'h4);

        do_fetch(32'h0000_0020, 0); do_exec(0, 0, 0, 32'h8);
        do_fetch(32'h0000_0020, 2); do_exec(0, 0, 0, 32'hC);
        do_fetch(32'h0000_0020, 0); do_exec(0, 0, 0, 32'h10);

        // beq taken / not taken
        do_fetch(32'h1000_FFFE, 0);
        chk("beq_opcode", {26'd0, opcode}, {26'd0, OP_BEQ});
        do_exec(1, 0, 1, 32'hC);
        do_fetch(32'h0000_0020, 0); do_exec(0, 0, 0, 32'h10);
        do_fetch(32'h1000_FFFE, 1); do_exec(1, 0, 0, 32'h14);

        // exec_done during WAIT and on the WAIT->EXEC edge
        wait_req();
        exec_done = 1'b1;
        jump = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("wait_ed_pc", pc, 32'h14);
        chk("wait_ed_req", {31'd0, imem_if.imem_req}, 32'd1);
        imem_if.imem_ready = 1'b1;
        imem_if.imem_rdata = 32'h0800_0003;
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        jump = 1'b0;
        imem_if.imem_ready = 1'b0;
        chk("edge_ed_valid", {31'd0, instr_valid}, 32'd1);
        chk("edge_ed_pc", pc, 32'h14);

        // stray ready in EXEC
        imem_if.imem_ready = 1'b1;
        imem_if.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_if.imem_ready = 1'b0;
        chk("stray_instr", instr, 32'h0800_0003);
        chk("stray_req", {31'd0, imem_if.imem_req}, 32'd0);
        do_exec(0, 1, 0, 32'hC);

        // longest legal wait, then wrap through 0xFFFF_FFFC
        do_fetch(32'h0800_0000, 14); do_exec(0, 1, 0, 32'h0);
        do_fetch(32'h1000_FFFE, 0); do_exec(1, 0, 1, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0020, 0);
        chk("wrap_addr", imem_if.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        do_exec(0, 0, 0, 32'h0);

        // async reset in WAIT with ready high
        do_fetch(32'h0000_0020, 0); do_exec(0, 0, 0, 32'h4);
        wait_req();
        imem_if.imem_ready = 1'b1;
        imem_if.imem_rdata = 32'h8C00_0000;
        #1 reset = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_req", {31'd0, imem_if.imem_req}, 32'd0);
        @(negedge clk);
        chk("arst_hold", instr, 32'h0);
        imem_if.imem_ready = 1'b0;
        reset = 1'b0;

        // timeout into HALT
        wait_req();
        repeat (14) @(negedge clk);
        chk("to_pre_fault", {31'd0, fetch_fault}, 32'd0);
        chk("to_pre_req", {31'd0, imem_if.imem_req}, 32'd1);
        @(negedge clk);
        chk("to_fault", {31'd0, fetch_fault}, 32'd1);
        chk("to_req", {31'd0, imem_if.imem_req}, 32'd0);
        imem_if.imem_ready = 1'b1;
        exec_done = 1'b1;
        jump = 1'b1;
        imem_if.imem_rdata = 32'h0800_0040;
        repeat (3) @(negedge clk);
        imem_if.imem_ready = 1'b0;
        exec_done = 1'b0;
        jump = 1'b0;
        chk("halt_pc", pc, 32'h0);
        chk("halt_fault", {31'd0, fetch_fault}, 32'd1);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_req", {31'd0, imem_if.imem_req}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("recover_fault", {31'd0, fetch_fault}, 32'd0);
        do_fetch(32'h0000_0020, 0); do_exec(0, 0, 0, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the main decoder in the non-pipelined MIPS core.
- Holds the PC and requests instructions from instruction memory over a ready handshake.
- Latches each fetched word into an instruction register and presents opcode[31:26] to the decoder.
- Waits for execute completion, then selects the next PC (PC+4, beq target or j target) from the decoder's branch/jump outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, maximum imem wait cycles before a fetch fault is flagged

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
imem_req  output  1  instruction memory read request
imem_addr  output  32  word-aligned fetch address (equals pc)
imem_rdata  input  32  instruction memory read data
imem_ready  input  1  imem_rdata valid this cycle
instr  output  32  instruction register
opcode  output  6  instr[31:26], to decoder
instr_valid  output  1  instr holds a fresh instruction awaiting execution
exec_done  input  1  current instruction has completed (one-cycle pulse)
branch  input  1  decoder beq indication
jump  input  1  decoder j indication
alu_zero  input  1  ALU zero flag for beq
pc  output  32  current PC
pc_plus4  output  32  pc + 4, combinational
fetch_fault  output  1  sticky; set on imem timeout

Behaviour:
- Reset is asynchronous, active-high, single clock domain. Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_fault=0, wait counter=0, state=FETCH.
- Reset asserted mid-fetch or mid-execute aborts the operation immediately. Nothing is latched on the deasserting edge.
- Four-state FSM: FETCH, WAIT, EXEC, HALT.
- FETCH: drive imem_req=1 and imem_addr=pc. Clear the wait counter. Go to WAIT next cycle.
- WAIT: hold imem_req=1 and imem_addr stable.
  - imem_ready=1: latch instr=imem_rdata, set instr_valid=1, drop imem_req, go to EXEC. Fetch latency is 2 cycles minimum from FETCH entry to instr_valid.
  - imem_ready=0: increment the counter. When the counter reaches MAX_WAIT with imem_ready still low, set fetch_fault=1, drop imem_req and go to HALT.
- EXEC: instr, opcode and pc are held stable; imem_req=0. imem_ready is ignored here; a stray ready pulse is not latched.
  - On exec_done=1: clear instr_valid, load the next pc, return to FETCH.
  - exec_done in the same cycle that instr_valid rises (WAIT->EXEC edge) is ignored; it counts only while state==EXEC.
- Next-PC selection, priority highest first:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch=1 and alu_zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}). Sign-extended offset; 32-bit modulo arithmetic, wrap at 2^32 silently.
  - Otherwise: pc_plus4. This includes branch=1 with alu_zero=0.
  - jump and branch asserted together: jump wins.
- pc_plus4 = pc + 32'd4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
- pc[1:0] is always 2'b00. RESET_PC must be word-aligned; the low bits are forced to 0 on load.
- HALT: all outputs hold, fetch_fault=1. Exit only via reset.
- opcode is a combinational slice of the instr register. The decoder samples it on the next rising edge.

Decomposition:
- Shared package holds:
  - FSM state encoding: FETCH=2'd0, WAIT=2'd1, EXEC=2'd2, HALT=2'd3.
  - Opcode constants used by both this block and the decoder: OP_RTYPE=6'b000000, OP_J=6'b000010, OP_BEQ=6'b000100, OP_LW=6'b100011, OP_SW=6'b101011.
  - Width constants: instruction 32, opcode 6.
- One sub-module: next_pc_sel. It is combinational: pc_plus4, instr, branch, jump, alu_zero -> next_pc, and is tested standalone. The FSM and registers stay in the top.

Test Plan:
- Reset release with RESET_PC=0, imem_ready one cycle after req, rdata=32'h0000_0020 -> instr_valid rises 2 cycles after reset release, opcode=6'b000000, pc=0. Then exec_done -> pc=4, imem_addr=4.
- pc=32'h0000_0010, instr=32'h1000_FFFE (beq offset -2), branch=1, alu_zero=1, exec_done -> pc=32'h0000_000C. Repeat with alu_zero=0 -> pc=32'h0000_0014.
- pc=32'h4000_0000, instr=32'h0800_0100 (j), jump=1 and branch=1 together -> pc=32'h4000_0400.
- imem_ready held low for MAX_WAIT=15 cycles -> fetch_fault=1, imem_req=0, state HALT. A later imem_ready/exec_done causes no pc change until reset.
- Reset asserted in WAIT with imem_ready=1 in the same cycle -> instr stays 0, instr_valid=0, pc=RESET_PC immediately (asynchronous).
- pc=32'hFFFF_FFFC, plain R-type, exec_done -> pc wraps to 32'h0000_0000. Also exec_done pulse during WAIT -> ignored, pc unchanged.
